echo_ranger: RTL and testbench



---
 rtl/echo_ranger.sv | 165 ++++++++++++++++
 tb/tb_echo_ranger.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/echo_ranger.sv
// Ultrasonic ranger sequencer: trigger pulse, echo width timing in microseconds,
// and sequential conversion to centimetres, repeating while enabled.
module echo_ranger #(
    parameter int unsigned CLKSPDMHZ  = 100,
    parameter int unsigned TRIG_US    = 10,
    parameter int unsigned TIMEOUT_US = 30000,
    parameter int unsigned HOLDOFF_US = 30000,
    parameter int unsigned CM_DIV     = 58
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        echo,
    output logic        trig,
    output logic        busy,
    output logic        valid,
    output logic        timeout,
    output logic [15:0] echo_us,
    output logic [9:0]  dist_cm
);

    localparam int unsigned PW = (CLKSPDMHZ > 1) ? $clog2(CLKSPDMHZ) : 1;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] TRIG      = 3'd1;
    localparam logic [2:0] WAIT_RISE = 3'd2;
    localparam logic [2:0] MEASURE   = 3'd3;
    localparam logic [2:0] DIVIDE    = 3'd4;
    localparam logic [2:0] HOLDOFF   = 3'd5;

    localparam logic [PW-1:0] PRE_LAST  = PW'(CLKSPDMHZ - 1);
    localparam logic [15:0]   TRIG_LAST = 16'(TRIG_US - 1);
    localparam logic [15:0]   TO_LAST   = 16'(TIMEOUT_US - 1);
    localparam logic [15:0]   HOLD_LAST = 16'(HOLDOFF_US - 1);
    localparam logic [15:0]   TO_VAL    = 16'(TIMEOUT_US);
    localparam logic [15:0]   DIVISOR   = 16'(CM_DIV);
    localparam logic [9:0]    QMAX      = 10'd1023;

    logic [2:0]    state_q, state_d;
    logic          echo_m_q, echo_s_q, echo_d_q;
    logic [PW-1:0] pre_q;
    logic [15:0]   us_q;
    logic [15:0]   meas_q, meas_d;
    logic [15:0]   rem_q, rem_d;
    logic [9:0]    quot_q, quot_d;
    logic          trig_q;
    logic          valid_q, valid_d;
    logic          timeout_q, timeout_d;
    logic [15:0]   echo_us_q, echo_us_d;
    logic [9:0]    dist_q, dist_d;

    logic tick, rise, fall, take_timeout;

    assign tick = (pre_q == PRE_LAST);
    assign rise = echo_s_q & ~echo_d_q;
    assign fall = ~echo_s_q & echo_d_q;

    always_comb begin
        state_d      = state_q;
        meas_d       = meas_q;
        rem_d        = rem_q;
        quot_d       = quot_q;
        valid_d      = 1'b0;
        timeout_d    = timeout_q;
        echo_us_d    = echo_us_q;
        dist_d       = dist_q;
        take_timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) state_d = TRIG;
            end
            TRIG: begin
                if (tick && us_q == TRIG_LAST) state_d = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (rise) state_d = MEASURE;
                else if (tick && us_q == TO_LAST) take_timeout = 1'b1;
            end
            MEASURE: begin
                // The fall-detect cycle completes the final microsecond of the pulse.
                if (fall) begin
                    state_d = DIVIDE;
                    meas_d  = us_q + {15'd0, tick};
                    rem_d   = us_q + {15'd0, tick};
                    quot_d  = '0;
                end else if (tick && us_q == TO_LAST) begin
                    take_timeout = 1'b1;
                end
            end
            DIVIDE: begin
                if (rem_q >= DIVISOR && quot_q != QMAX) begin
                    rem_d  = rem_q - DIVISOR;
                    quot_d = quot_q + 10'd1;
                end else begin
                    state_d   = HOLDOFF;
                    valid_d   = 1'b1;
                    timeout_d = 1'b0;
                    echo_us_d = meas_q;
                    dist_d    = quot_q;
                end
            end
            HOLDOFF: begin
                if (tick && us_q == HOLD_LAST) state_d = enable ? TRIG : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (take_timeout) begin
            state_d   = HOLDOFF;
            valid_d   = 1'b1;
            timeout_d = 1'b1;
            echo_us_d = TO_VAL;
            dist_d    = QMAX;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            echo_m_q  <= 1'b0;
            echo_s_q  <= 1'b0;
            echo_d_q  <= 1'b0;
            pre_q     <= '0;
            us_q      <= '0;
            meas_q    <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            trig_q    <= 1'b0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            echo_us_q <= '0;
            dist_q    <= '0;
        end else begin
            state_q   <= state_d;
            echo_m_q  <= echo;
            echo_s_q  <= echo_m_q;
            echo_d_q  <= echo_s_q;
            meas_q    <= meas_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            trig_q    <= (state_d == TRIG);
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            echo_us_q <= echo_us_d;
            dist_q    <= dist_d;
            // Timebase restarts on every transition so each state lasts an exact clock count.
            if (state_d != state_q) begin
                pre_q <= '0;
                us_q  <= '0;
            end else if (tick) begin
                pre_q <= '0;
                us_q  <= us_q + 16'd1;
            end else begin
                pre_q <= pre_q + 1'b1;
            end
        end
    end

    assign trig    = trig_q;
    assign busy    = (state_q != IDLE);
    assign valid   = valid_q;
    assign timeout = timeout_q;
    assign echo_us = echo_us_q;
    assign dist_cm = dist_q;

endmodule

// File: tb/tb_echo_ranger.sv
// Directed and randomized bench for echo_ranger using two parameterizations.
`timescale 1ns/1ps
module tb_echo_ranger;

    localparam int A_CPU = 4, A_TRIG = 10, A_TO = 500, A_HOLD = 200;
    localparam int B_CPU = 2, B_TRIG = 10, B_TO = 12000, B_HOLD = 20;
    localparam int CM = 58;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, enable_a, enable_b, sel, echo_drv;
    logic echo_a, echo_b;
    logic trig_a, busy_a, valid_a, timeout_a;
    logic trig_b, busy_b, valid_b, timeout_b;
    logic [15:0] echo_us_a, echo_us_b;
    logic [9:0]  dist_cm_a, dist_cm_b;

    assign echo_a = ~sel & echo_drv;
    assign echo_b = sel & echo_drv;

    echo_ranger #(
        .CLKSPDMHZ(A_CPU), .TRIG_US(A_TRIG), .TIMEOUT_US(A_TO), .HOLDOFF_US(A_HOLD), .CM_DIV(CM)
    ) u_a (
        .clk(clk), .reset_n(reset_n), .enable(enable_a), .echo(echo_a), .trig(trig_a),
        .busy(busy_a), .valid(valid_a), .timeout(timeout_a), .echo_us(echo_us_a),
        .dist_cm(dist_cm_a)
    );

    echo_ranger #(
        .CLKSPDMHZ(B_CPU), .TRIG_US(B_TRIG), .TIMEOUT_US(B_TO), .HOLDOFF_US(B_HOLD), .CM_DIV(CM)
    ) u_b (
        .clk(clk), .reset_n(reset_n), .enable(enable_b), .echo(echo_b), .trig(trig_b),
        .busy(busy_b), .valid(valid_b), .timeout(timeout_b), .echo_us(echo_us_b),
        .dist_cm(dist_cm_b)
    );

    logic trig_m, busy_m, valid_m, timeout_m;
    logic [15:0] echo_us_m;
    logic [9:0]  dist_m;
    assign trig_m    = sel ? trig_b : trig_a;
    assign busy_m    = sel ? busy_b : busy_a;
    assign valid_m   = sel ? valid_b : valid_a;
    assign timeout_m = sel ? timeout_b : timeout_a;
    assign echo_us_m = sel ? echo_us_b : echo_us_a;
    assign dist_m    = sel ? dist_cm_b : dist_cm_a;

    int tests = 0;
    int fails = 0;
    int vcount = 0;

    always @(posedge clk) if (valid_m === 1'b1) vcount <= vcount + 1;

    function automatic int cpu_f();
        return sel ? B_CPU : A_CPU;
    endfunction
    function automatic int trig_f();
        return (sel ? B_TRIG : A_TRIG) * cpu_f();
    endfunction
    function automatic int hold_f();
        return (sel ? B_HOLD : A_HOLD) * cpu_f();
    endfunction
    // Reference: whole centimetres from whole microseconds, clamped to the 10-bit field.
    function automatic int exp_cm(int us);
        int q;
        q = us / CM;
        return (q > 1023) ? 1023 : q;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(string tag, int obs, int lo, int hi);
        tests++;
        assert (obs >= lo && obs <= hi)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic wait_trig(string tag, int bound, output int cyc);
        cyc = 0;
        while (trig_m !== 1'b1 && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, ".trig_seen"}, trig_m, 1);
    endtask

    // Entered on the first negedge with trig high; leaves on the first with trig low.
    task automatic trig_phase(string tag);
        int w;
        w = 0;
        check({tag, ".busy"}, busy_m, 1);
        while (trig_m === 1'b1 && w < 4000) begin
            @(negedge clk);
            w++;
        end
        check({tag, ".trig_width"}, w, trig_f());
    endtask

    task automatic wait_valid(string tag, int bound, output int lat);
        lat = 0;
        while (valid_m !== 1'b1 && lat < bound) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".valid"}, valid_m, 1);
    endtask

    task automatic check_result(string tag, logic to, int us, int cm);
        check({tag, ".timeout"}, timeout_m, to);
        check({tag, ".echo_us"}, echo_us_m, us);
        check({tag, ".dist_cm"}, dist_m, cm);
        @(negedge clk);
        check({tag, ".valid_one_cycle"}, valid_m, 0);
        check({tag, ".echo_us_hold"}, echo_us_m, us);
    endtask

    task automatic next_trig(string tag, int vb);
        int cyc;
        wait_trig(tag, hold_f() + 50, cyc);
        check({tag, ".holdoff"}, cyc + 1, hold_f());
        check({tag, ".valid_count"}, vcount, vb + 1);
    endtask

    task automatic good_shot(string tag, int w, output int vb);
        int lat, q;
        vb = vcount;
        trig_phase(tag);
        repeat ($urandom_range(1, 20)) @(negedge clk);
        echo_drv = 1'b1;
        repeat (w * cpu_f()) @(negedge clk);
        echo_drv = 1'b0;
        q = exp_cm(w);
        wait_valid(tag, q + 20, lat);
        check_range({tag, ".latency"}, lat, 1, q + 5);
        check_result(tag, 1'b0, w, q);
    endtask

    initial begin
        int c, vb, lat, w, hi;
        reset_n = 1'b0; enable_a = 1'b0; enable_b = 1'b0; sel = 1'b1; echo_drv = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.trig_a", trig_a, 0);
        check("rst.busy_a", busy_a, 0);
        check("rst.valid_a", valid_a, 0);
        check("rst.timeout_a", timeout_a, 0);
        check("rst.echo_us_a", echo_us_a, 0);
        check("rst.dist_cm_a", dist_cm_a, 0);
        check("rst.trig_b", trig_b, 0);
        check("rst.busy_b", busy_b, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle.busy_b", busy_b, 0);

        // Long-range instance: nominal, sub-centimetre, far, then random widths.
        enable_b = 1'b1;
        wait_trig("b580", 5, c);
        good_shot("b580", 580, vb);
        next_trig("b580", vb);
        good_shot("b57", 57, vb);
        next_trig("b57", vb);
        good_shot("b11600", 11600, vb);
        next_trig("b11600", vb);
        for (int i = 0; i < 3; i++) begin
            w = $urandom_range(1, 1500);
            good_shot($sformatf("b_rand%0d_w%0d", i, w), w, vb);
            if (i < 2) next_trig($sformatf("b_rand%0d", i), vb);
        end
        enable_b = 1'b0;
        c = 0;
        while (busy_b === 1'b1 && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("b_stop.busy", busy_b, 0);

        // Short-timeout instance.
        sel = 1'b0;
        enable_a = 1'b1;
        wait_trig("a_to", 5, c);
        vb = vcount;
        trig_phase("a_to");
        wait_valid("a_to", 2100, lat);
        check("a_to.latency", lat, A_TO * A_CPU);
        check_result("a_to", 1'b1, A_TO, 1023);
        next_trig("a_to", vb);

        good_shot("a_clr", 100, vb);
        echo_drv = 1'b1;  // raised during holdoff so it is already high when trig starts
        next_trig("a_clr", vb);

        vb = vcount;
        trig_phase("a_stuck");
        wait_valid("a_stuck", 2100, lat);
        check("a_stuck.latency", lat, A_TO * A_CPU);
        check_result("a_stuck", 1'b1, A_TO, 1023);
        echo_drv = 1'b0;
        next_trig("a_stuck", vb);

        vb = vcount;
        trig_phase("a_long");
        repeat (3) @(negedge clk);
        echo_drv = 1'b1;
        wait_valid("a_long", 2100, lat);
        check_range("a_long.latency", lat, A_TO * A_CPU, A_TO * A_CPU + 6);
        check_result("a_long", 1'b1, A_TO, 1023);
        echo_drv = 1'b0;
        next_trig("a_long", vb);

        for (int i = 0; i < 2; i++) begin
            w = $urandom_range(1, 480);
            good_shot($sformatf("a_rand%0d_w%0d", i, w), w, vb);
            next_trig($sformatf("a_rand%0d", i), vb);
        end

        // Drop enable mid-echo: result still reported, then the block goes idle.
        vb = vcount;
        trig_phase("a_drop");
        repeat (5) @(negedge clk);
        echo_drv = 1'b1;
        repeat (100 * A_CPU) @(negedge clk);
        enable_a = 1'b0;
        repeat (100 * A_CPU) @(negedge clk);
        echo_drv = 1'b0;
        wait_valid("a_drop", exp_cm(200) + 20, lat);
        check_result("a_drop", 1'b0, 200, exp_cm(200));
        hi = 0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (trig_a === 1'b1) hi++;
        end
        check("a_drop.no_trig", hi, 0);
        check("a_drop.busy", busy_a, 0);
        check("a_drop.valid_count", vcount, vb + 1);

        // Asynchronous reset in the middle of a trigger pulse.
        enable_a = 1'b1;
        wait_trig("a_rst", 5, c);
        repeat (15) @(negedge clk);
        check("a_rst.pre_trig", trig_a, 1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("a_rst.trig", trig_a, 0);
        check("a_rst.busy", busy_a, 0);
        check("a_rst.valid", valid_a, 0);
        check("a_rst.timeout", timeout_a, 0);
        check("a_rst.echo_us", echo_us_a, 0);
        check("a_rst.dist_cm", dist_cm_a, 0);
        check("a_rst.echo_us_b", echo_us_b, 0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_trig("a_fresh", 5, c);
        trig_phase("a_fresh");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
